ballot_controller: RTL and testbench



---
 rtl/ballot_controller.sv | 171 +++++++++++++++++
 tb/tb_ballot_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_controller.sv
// ballot_controller
// Sequences one ballot per officer arm between the candidate button
// debouncers and the vote logger / LED display. Rejects multi-button
// (spoiled) ballots, expires an armed ballot that is never cast, and in
// results mode scans the four candidate tallies onto the display.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high
//   mode           0 = voting, 1 = results
//   arm            officer enable (level or pulse)
//   vote_valid     debounced single-cycle pulses, bit i = candidate i+1
//   log_valid      one-hot single-cycle increment strobe to the logger
//   ready          high while a ballot is armed
//   confirm        high during the post-ballot confirm window
//   spoiled_count  spoiled ballots, saturating at 255
//   timeout_count  expired ballots, saturating at 255
//   disp_sel       candidate index shown in results mode
//   disp_valid     high in results mode
module ballot_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CONFIRM_CYCLES = 10,
  parameter int unsigned DWELL_CYCLES   = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       arm,
  input  logic [3:0] vote_valid,
  output logic [3:0] log_valid,
  output logic       ready,
  output logic       confirm,
  output logic [7:0] spoiled_count,
  output logic [7:0] timeout_count,
  output logic [1:0] disp_sel,
  output logic       disp_valid
);

  localparam int unsigned MAX_TC     = (TIMEOUT_CYCLES > CONFIRM_CYCLES) ?
                                       TIMEOUT_CYCLES : CONFIRM_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_TC > DWELL_CYCLES) ? MAX_TC : DWELL_CYCLES;
  localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam int unsigned COUNT_W    = 8;

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CONFIRM_LAST = TIMER_W'(CONFIRM_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DWELL_LAST   = TIMER_W'(DWELL_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    ARMED   = 2'd1,
    CONFIRM = 2'd2,
    RESULTS = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [3:0]         log_next;
  logic [COUNT_W-1:0] spoiled_next, timeout_next;
  logic [1:0]         sel_next;
  logic               single_vote, multi_vote;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign single_vote = (vote_valid != 4'd0) &&
                       ((vote_valid & 4'(vote_valid - 4'd1)) == 4'd0);
  assign multi_vote  = (vote_valid != 4'd0) && !single_vote;

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= CLOSED;
      timer         <= '0;
      log_valid     <= '0;
      ready         <= 1'b0;
      confirm       <= 1'b0;
      spoiled_count <= '0;
      timeout_count <= '0;
      disp_sel      <= '0;
      disp_valid    <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      log_valid     <= log_next;
      ready         <= (state_next == ARMED);
      confirm       <= (state_next == CONFIRM);
      spoiled_count <= spoiled_next;
      timeout_count <= timeout_next;
      disp_sel      <= sel_next;
      disp_valid    <= (state_next == RESULTS);
    end
  end

  // Next-state, shared timer, counters and display index.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    log_next     = '0;
    spoiled_next = spoiled_count;
    timeout_next = timeout_count;
    sel_next     = disp_sel;

    case (state)
      CLOSED: begin
        if (mode) begin
          state_next = RESULTS;
          timer_next = '0;
          sel_next   = '0;
        end else if (arm) begin
          state_next = ARMED;
          timer_next = '0;
        end
      end

      ARMED: begin
        // A vote in the expiry cycle takes precedence over the timeout.
        if (mode) begin
          state_next = RESULTS;
          timer_next = '0;
          sel_next   = '0;
        end else if (single_vote) begin
          log_next   = vote_valid;
          state_next = CONFIRM;
          timer_next = '0;
        end else if (multi_vote) begin
          if (spoiled_count != COUNT_MAX) begin
            spoiled_next = spoiled_count + COUNT_W'(1);
          end
          state_next = CONFIRM;
          timer_next = '0;
        end else if (timer == TIMEOUT_LAST) begin
          if (timeout_count != COUNT_MAX) begin
            timeout_next = timeout_count + COUNT_W'(1);
          end
          state_next = CLOSED;
          timer_next = '0;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end

      CONFIRM: begin
        if (timer == CONFIRM_LAST) begin
          state_next = CLOSED;
          timer_next = '0;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end

      RESULTS: begin
        if (!mode) begin
          state_next = CLOSED;
          timer_next = '0;
          sel_next   = '0;
        end else if (timer == DWELL_LAST) begin
          timer_next = '0;
          sel_next   = disp_sel + 2'd1;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end

      default: begin
        state_next = CLOSED;
        timer_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ballot_controller.sv
// Testbench for ballot_controller: table-driven vectors, hand-written
// multi-cycle sequences, and randomized stimulus, all compared every cycle
// against a timestamp-based reference model of the ballot rules.
module tb_ballot_controller;

  localparam int TIMEOUT = 1000;
  localparam int CONFIRM = 10;
  localparam int DWELL   = 50;

  logic       clock;
  logic       reset;
  logic       mode;
  logic       arm;
  logic [3:0] vote_valid;
  logic [3:0] log_valid;
  logic       ready;
  logic       confirm;
  logic [7:0] spoiled_count;
  logic [7:0] timeout_count;
  logic [1:0] disp_sel;
  logic       disp_valid;

  ballot_controller #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .CONFIRM_CYCLES(CONFIRM),
    .DWELL_CYCLES  (DWELL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .arm          (arm),
    .vote_valid   (vote_valid),
    .log_valid    (log_valid),
    .ready        (ready),
    .confirm      (confirm),
    .spoiled_count(spoiled_count),
    .timeout_count(timeout_count),
    .disp_sel     (disp_sel),
    .disp_valid   (disp_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks the ballot phase with absolute cycle stamps.
  localparam int PH_IDLE = 0, PH_BALLOT = 1, PH_CONF = 2, PH_SCAN = 3;
  int         cyc = 0;
  int         ph = PH_IDLE;
  int         ballot_start = 0, conf_end = 0, scan_start = 0;
  int         m_spoil = 0, m_tout = 0;
  logic [3:0] m_log = 4'd0;

  task automatic model_step(input logic r, input logic m, input logic a, input logic [3:0] v);
    int n;
    n     = cyc + 1;
    m_log = 4'd0;
    if (r) begin
      ph = PH_IDLE; m_spoil = 0; m_tout = 0;
    end else begin
      case (ph)
        PH_IDLE: begin
          if (m) begin ph = PH_SCAN; scan_start = n; end
          else if (a) begin ph = PH_BALLOT; ballot_start = n; end
        end
        PH_BALLOT: begin
          if (m) begin ph = PH_SCAN; scan_start = n; end
          else if ($countones(v) == 1) begin m_log = v; ph = PH_CONF; conf_end = n + CONFIRM - 1; end
          else if ($countones(v) > 1) begin
            if (m_spoil < 255) m_spoil++;
            ph = PH_CONF; conf_end = n + CONFIRM - 1;
          end else if (n - ballot_start == TIMEOUT) begin
            if (m_tout < 255) m_tout++;
            ph = PH_IDLE;
          end
        end
        PH_CONF: if (cyc == conf_end) ph = PH_IDLE;
        default: if (!m) ph = PH_IDLE;
      endcase
    end
    cyc = n;
  endtask

  function automatic logic [24:0] model_outputs();
    logic [1:0] sel;
    sel = (ph == PH_SCAN) ? 2'(((cyc - scan_start) / DWELL) % 4) : 2'd0;
    return {m_log, ph == PH_BALLOT, ph == PH_CONF, 8'(m_spoil), 8'(m_tout), sel, ph == PH_SCAN};
  endfunction

  function automatic logic [24:0] dut_outputs();
    return {log_valid, ready, confirm, spoiled_count, timeout_count, disp_sel, disp_valid};
  endfunction

  // One clock: drive inputs, clock, advance the model, compare after the edge.
  task automatic step(input logic r, input logic m, input logic a, input logic [3:0] v);
    reset = r; mode = m; arm = a; vote_valid = v;
    @(posedge clock);
    model_step(r, m, a, v);
    #1;
    check("model", 32'(dut_outputs()), 32'(model_outputs()));
  endtask

  typedef struct packed {
    logic       rst;
    logic       md;
    logic       ar;
    logic [3:0] vv;
    logic [3:0] e_log;
    logic       e_ready;
    logic       e_conf;
    logic       e_disp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic m, input logic a, input logic [3:0] v,
                              input logic [3:0] el, input logic er, input logic ec, input logic ed);
    vec_t x;
    x = '{rst: r, md: m, ar: a, vv: v, e_log: el, e_ready: er, e_conf: ec, e_disp: ed};
    return x;
  endfunction

  int k;

  initial begin
    reset = 1'b1; mode = 1'b0; arm = 1'b0; vote_valid = 4'd0;

    // Single vote: reset, arm pulse, vote two cycles later.
    vecs.push_back(mk(1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0100, 4'b0100, 0, 1, 0));
    for (int i = 0; i < CONFIRM - 1; i++) vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    // Spoil and lockout: votes during confirm and in CLOSED log nothing.
    vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0011, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0));
    for (int i = 0; i < CONFIRM - 2; i++) vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].md, vecs[i].ar, vecs[i].vv);
      check($sformatf("vec%0d", i), 32'({log_valid, ready, confirm, disp_valid}),
            32'({vecs[i].e_log, vecs[i].e_ready, vecs[i].e_conf, vecs[i].e_disp}));
    end
    check("spoil_after_vecs", 32'(spoiled_count), 32'd1);
    check("tout_after_vecs", 32'(timeout_count), 32'd0);

    // Timeout: ready falls exactly TIMEOUT cycles after it rose.
    step(0, 0, 1, 4'd0);
    check("armed_ready", 32'(ready), 32'd1);
    k = 0;
    while (ready && k < 2 * TIMEOUT) begin
      step(0, 0, 0, 4'd0);
      k++;
    end
    check("timeout_len", 32'(k), 32'(TIMEOUT));
    check("timeout_count", 32'(timeout_count), 32'd1);

    // Vote in the expiry cycle wins over the timeout.
    step(0, 0, 1, 4'd0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 4'd0);
    check("race_still_ready", 32'(ready), 32'd1);
    step(0, 0, 0, 4'b1000);
    check("race_log", 32'(log_valid), 32'b1000);
    check("race_tout", 32'(timeout_count), 32'd1);
    for (int i = 0; i < CONFIRM; i++) step(0, 0, 0, 4'd0);

    // Results scan from CLOSED.
    step(0, 1, 0, 4'd0);
    check("scan_entry", 32'({disp_valid, disp_sel}), 32'b100);
    for (int i = 1; i <= 4 * DWELL; i++) begin
      step(0, 1, i[0], 4'b0001);
      if (i % DWELL == 0 || i % DWELL == DWELL - 1)
        check($sformatf("scan_sel_%0d", i), 32'({disp_valid, disp_sel}), 32'({1'b1, 2'((i / DWELL) % 4)}));
    end
    step(0, 0, 0, 4'd0);
    check("scan_exit", 32'({disp_valid, disp_sel}), 32'd0);

    // Mode change inside ARMED aborts with no log and no count.
    step(0, 0, 1, 4'd0);
    step(0, 0, 0, 4'd0);
    step(0, 1, 0, 4'b0100);
    check("abort", 32'({log_valid, ready, disp_valid, disp_sel}), 32'b0000_0_1_00);
    check("abort_counts", 32'({spoiled_count, timeout_count}), 32'h0101);
    step(0, 0, 0, 4'd0);

    // Saturation: 260 more spoiled ballots.
    for (int b = 0; b < 260; b++) begin
      step(0, 0, 1, 4'd0);
      step(0, 0, 0, 4'b1111);
      for (int i = 0; i < CONFIRM; i++) step(0, 0, 0, 4'd0);
    end
    check("spoil_saturate", 32'(spoiled_count), 32'd255);

    // Reset in the middle of confirm.
    step(0, 0, 1, 4'd0);
    step(0, 0, 0, 4'b0001);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'd0);
    check("pre_reset_conf", 32'(confirm), 32'd1);
    step(1, 0, 0, 4'd0);
    check("reset_clear", 32'(dut_outputs()), 32'd0);
    step(0, 0, 1, 4'd0);
    step(0, 0, 0, 4'b0010);
    check("post_reset_vote", 32'({log_valid, confirm}), 32'b0010_1);
    for (int i = 0; i < CONFIRM; i++) step(0, 0, 0, 4'd0);

    // Randomized traffic against the model.
    begin
      logic rm;
      rm = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 63) == 0) rm = ~rm;
        step($urandom_range(0, 499) == 0, rm, $urandom_range(0, 7) == 0,
             ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
